serializer: RTL and testbench
=============================

// Module: serializer
// PURPOSE
//  Parallel-to-serial transmit stage feeding deserializer: serial_out_o/enable_o/start_o
//  connect directly to its serial_in_i/enable_i/start_i (same DATA_WIDTH/HAS_ECC).
//  Accepts a word on a valid/ready handshake, optionally Hamming-encodes it, shifts it MSB first.
//  Bit rate is programmable by a clock-enable divider, with a configurable idle gap between frames.
// PARAMETERS
//  DATA_WIDTH  8  payload width in bits
//  HAS_ECC     0  1: transmit CODED_WIDTH-bit frame {data, check bits} (hamming_defines.svh)
//  CLK_DIV     1  clk_i cycles per serial bit, >=1
//  GAP_CYCLES  0  idle clk_i cycles after last bit before ready_o returns, >=0
// PORTS
//  clk_i         in   1           clock
//  rst_n_i       in   1           async active-low reset
//  data_i        in   DATA_WIDTH  parallel word, sampled on handshake
//  valid_i       in   1           source has word
//  ready_o       out  1           block can accept word
//  serial_out_o  out  1           serial bit, stable across each bit period
//  enable_o      out  1           one-cycle strobe per bit, last cycle of bit period
//  start_o       out  1           high with enable_o of bit 0 only
//  busy_o        out  1           frame or gap in progress
// BEHAVIOUR
//  - All outputs registered. Reset (async) -> ready_o=0, serial_out_o=0, enable_o=0, start_o=0,
//    busy_o=0, state IDLE. ready_o rises on first clk_i edge after rst_n_i release.
//  - FRAME_WIDTH = HAS_ECC ? CODED_WIDTH : DATA_WIDTH. HAS_ECC=1: frame = {data_i, check bits},
//    check bits (CODE_BITS) in the positional order hamming_pad reinserts them, MSB first.
//    Encode combinational on data_i, captured with it.
//  - Counters: bit_cnt $clog2(FRAME_WIDTH)+1 bits, div_cnt $clog2(CLK_DIV)+1 bits, gap counter
//    $clog2(GAP_CYCLES+1)+1 bits; no wrap in normal operation.
//  - FSM IDLE -> SHIFT -> GAP -> IDLE (GAP skipped when GAP_CYCLES=0).
//  - IDLE: ready_o=1, serial_out_o=0. Handshake = valid_i && ready_o at edge E0: load shift
//    reg with frame, bit_cnt=0, div_cnt=0, ready_o<=0, busy_o<=1, -> SHIFT.
//  - SHIFT: bit k (frame[FRAME_WIDTH-1-k]) on serial_out_o during cycles E0+1+k*CLK_DIV ..
//    E0+(k+1)*CLK_DIV. enable_o high only in last cycle of each bit period; start_o high only
//    in that cycle for k=0. After enable_o of k=FRAME_WIDTH-1 -> GAP (or IDLE), serial_out_o<=0.
//  - GAP: GAP_CYCLES cycles, enable_o/start_o low. Then IDLE, ready_o<=1, busy_o<=0.
//  - CLK_DIV=1, GAP_CYCLES=0: enable_o high FRAME_WIDTH consecutive cycles; ready_o low
//    FRAME_WIDTH+1 cycles per word (accept, bits, ready). No overlap of frames.
//  - data_i/valid_i ignored while ready_o=0; word is captured, source may change data_i.
//  - Never enable_o without a loaded frame; never start_o without enable_o.
//  - Reset mid-frame: outputs return to reset values immediately, frame discarded.
//    Deserializer sees no further enable and holds in_packet until next start.
//  - Downstream latency: deserializer valid_o 1 cycle after last enable_o (HAS_ECC=0),
//    2 cycles (HAS_ECC=1).
// TESTING (loopback into deserializer with matching parameters)
//  1. W=8,ECC=0,DIV=1: send 0xA5 -> serial 1,0,1,0,0,1,0,1 on 8 consecutive cycles, start_o on
//     1st, deserializer parallel_out_o=0xA5 with valid_o one cycle after last bit.
//  2. DIV=4: send 0x3C -> each bit held 4 cycles, enable_o every 4th cycle (8 pulses),
//     ready_o low 33 cycles.
//  3. GAP=2, valid_i held high with 0x01 then 0xFF -> two frames, 2 idle cycles + handshake
//     cycle between, both words received in order.
//  4. ECC=1: 256 random words -> received data matches, num_errors_o=0.
//     Bench flips bit 5 of one frame in flight -> data corrected, num_errors_o=1.
//  5. rst_n_i low during bit 3 of 0x96 -> outputs 0 asynchronously. After release ready_o=1
//     next edge; 0x5A then transmits and is received correctly.
//  6. valid_i low 50 cycles -> ready_o stays 1, enable_o/start_o/serial_out_o stay 0.

Source files
------------

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial transmit stage with optional Hamming encode
// Accepts a word on valid/ready, shifts it MSB first at a divided bit rate, then idles for a gap.
module serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int HAS_ECC    = 0,
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  serial_out_o,
  output logic                  enable_o,
  output logic                  start_o,
  output logic                  busy_o
);
  function automatic int f_code_bits(input int width);
    int r;
    r = 1;
    while ((1 << r) < (width + r + 1)) r = r + 1;
    return r;
  endfunction

  localparam int CODE_BITS   = f_code_bits(DATA_WIDTH);
  localparam int CODED_WIDTH = DATA_WIDTH + CODE_BITS;
  localparam int FRAME_WIDTH = (HAS_ECC != 0) ? CODED_WIDTH : DATA_WIDTH;
  localparam int BIT_W       = $clog2(FRAME_WIDTH) + 1;
  localparam int DIV_W       = $clog2(CLK_DIV) + 1;
  localparam int GAP_W       = $clog2(GAP_CYCLES + 1) + 1;
  localparam int GAP_LAST    = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  // Check bit i covers codeword positions with bit i set; data fills non-power-of-two positions from 3 up.
  function automatic logic [CODE_BITS-1:0] f_check(input logic [DATA_WIDTH-1:0] data);
    logic [CODE_BITS-1:0] chk;
    int d;
    chk = '0;
    d = 0;
    for (int pos = 1; pos <= CODED_WIDTH; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (data[d]) chk = chk ^ pos[CODE_BITS-1:0];
        d = d + 1;
      end
    end
    return chk;
  endfunction

  logic [FRAME_WIDTH-1:0] w_frame;

  generate
    if (HAS_ECC != 0) begin : g_ecc
      assign w_frame = {data_i, f_check(data_i)};
    end else begin : g_raw
      assign w_frame = data_i;
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t                 r_state;
  logic [FRAME_WIDTH-1:0] r_shift;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [DIV_W-1:0]       r_div_cnt;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic                   w_bit_last_cycle;

  assign w_bit_last_cycle = (r_div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_gap_cnt    <= '0;
      ready_o      <= 1'b0;
      serial_out_o <= 1'b0;
      enable_o     <= 1'b0;
      start_o      <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      enable_o <= 1'b0;
      start_o  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          serial_out_o <= 1'b0;
          if (valid_i && ready_o) begin
            r_shift   <= w_frame;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b1;
            r_state   <= S_SHIFT;
          end else begin
            ready_o <= 1'b1;
          end
        end
        S_SHIFT: begin
          // bit_cnt reaching FRAME_WIDTH means the last bit period has just finished
          if (r_bit_cnt == BIT_W'(FRAME_WIDTH)) begin
            serial_out_o <= 1'b0;
            if (GAP_CYCLES > 0) begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end else begin
              ready_o <= 1'b1;
              busy_o  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            if (r_div_cnt == '0) begin
              serial_out_o <= r_shift[FRAME_WIDTH-1];
              r_shift      <= r_shift << 1;
            end
            if (w_bit_last_cycle) begin
              enable_o  <= 1'b1;
              start_o   <= (r_bit_cnt == '0);
              r_div_cnt <= '0;
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - two serializer configurations checked by a behavioural serial receiver
module tb_serializer;
  localparam int B_DIV = 3;
  localparam int B_GAP = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_rdy, a_ser, a_en, a_start, a_busy;
  logic       b_rdy, b_ser, b_en, b_start, b_busy;

  serializer #(.DATA_WIDTH(8), .HAS_ECC(0), .CLK_DIV(1), .GAP_CYCLES(0)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(a_data), .valid_i(a_valid), .ready_o(a_rdy),
    .serial_out_o(a_ser), .enable_o(a_en), .start_o(a_start), .busy_o(a_busy)
  );

  serializer #(.DATA_WIDTH(8), .HAS_ECC(1), .CLK_DIV(B_DIV), .GAP_CYCLES(B_GAP)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(b_data), .valid_i(b_valid), .ready_o(b_rdy),
    .serial_out_o(b_ser), .enable_o(b_en), .start_o(b_start), .busy_o(b_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver-side decode: full-codeword syndrome, single-bit correction. Returns {corrected, data}.
  function automatic logic [8:0] hdec(input logic [11:0] f);
    logic [12:0] cw;
    logic [3:0]  syn;
    logic [7:0]  dat;
    int d;
    cw = '0;
    cw[1] = f[0];
    cw[2] = f[1];
    cw[4] = f[2];
    cw[8] = f[3];
    d = 0;
    for (int p = 3; p <= 12; p++) if ((p & (p - 1)) != 0) begin cw[p] = f[4 + d]; d++; end
    syn = '0;
    for (int p = 1; p <= 12; p++) if (cw[p]) syn = syn ^ p[3:0];
    if (syn != 0 && syn <= 12) cw[syn] = ~cw[syn];
    d = 0;
    dat = '0;
    for (int p = 3; p <= 12; p++) if ((p & (p - 1)) != 0) begin dat[d] = cw[p]; d++; end
    return {syn != 0, dat};
  endfunction

  logic [7:0] a_q[$];
  logic [7:0] a_acc = '0;
  int a_cnt = 0, a_rx = 0, a_en_total = 0, a_start_cyc = 0, a_last_en_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_cnt = 0;
    end else if (a_en) begin
      check("a_start_bit0", a_start, a_cnt == 0);
      check("a_en_busy", a_busy, 1);
      if (a_start) a_start_cyc = cyc;
      a_last_en_cyc = cyc;
      a_en_total++;
      a_acc = {a_acc[6:0], a_ser};
      a_cnt++;
      if (a_cnt == 8) begin
        a_cnt = 0;
        a_rx++;
        check("a_q_nonempty", a_q.size() != 0, 1);
        if (a_q.size() != 0) check("a_word", a_acc, a_q.pop_front());
      end
    end else if (a_start) begin
      check("a_start_without_en", a_start, 0);
    end
  end

  logic [8:0]  b_q[$];
  logic [11:0] b_acc = '0;
  logic [8:0]  b_dec;
  logic [8:0]  b_exp;
  logic        b_bit;
  int b_cnt = 0, b_rx = 0, b_nerr = 0, b_end_cyc = 0, b_gap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_cnt = 0;
    end else if (b_en) begin
      check("b_start_bit0", b_start, b_cnt == 0);
      check("b_en_busy", b_busy, 1);
      if (b_start) b_gap = cyc - b_end_cyc;
      b_bit = b_ser;
      if (b_cnt == 5 && b_q.size() != 0 && b_q[0][8]) b_bit = ~b_bit;
      b_acc = {b_acc[10:0], b_bit};
      b_cnt++;
      if (b_cnt == 12) begin
        b_cnt = 0;
        b_rx++;
        b_end_cyc = cyc;
        b_dec = hdec(b_acc);
        b_nerr += int'(b_dec[8]);
        check("b_q_nonempty", b_q.size() != 0, 1);
        if (b_q.size() != 0) begin
          b_exp = b_q.pop_front();
          check("b_word", b_dec[7:0], b_exp[7:0]);
          check("b_corrected", b_dec[8], b_exp[8]);
        end
      end
    end else if (b_start) begin
      check("b_start_without_en", b_start, 0);
    end
  end

  task automatic send_a(input logic [7:0] d, output int drive_cyc);
    int i;
    @(negedge clk);
    for (i = 0; i < 300 && !a_rdy; i++) @(negedge clk);
    check("a_ready_wait", a_rdy, 1);
    drive_cyc = cyc;
    if (a_rdy) begin
      a_data  = d;
      a_valid = 1'b1;
      a_q.push_back(d);
      @(negedge clk);
      a_valid = 1'b0;
      a_data  = 8'($urandom);
    end
  endtask

  task automatic send_b(input logic [7:0] d, input logic flip);
    int i;
    @(negedge clk);
    for (i = 0; i < 300 && !b_rdy; i++) @(negedge clk);
    check("b_ready_wait", b_rdy, 1);
    if (b_rdy) begin
      b_data  = d;
      b_valid = 1'b1;
      b_q.push_back({flip, d});
      @(negedge clk);
      b_valid = 1'b0;
      b_data  = 8'($urandom);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog n_tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc, n, e0, r0, nerr0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("a_reset_outputs", {a_rdy, a_ser, a_en, a_start, a_busy}, 0);
    check("b_reset_outputs", {b_rdy, b_ser, b_en, b_start, b_busy}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("a_ready_after_reset", a_rdy, 1);
    check("b_ready_after_reset", b_rdy, 1);

    // A: single 0xA5 frame timing
    e0 = a_en_total;
    r0 = a_rx;
    send_a(8'hA5, dc);
    for (n = 0; n < 500 && !a_rdy; n++) @(negedge clk);
    check("a_ready_low_cycles", n, 9);
    check("a_start_latency", a_start_cyc - dc, 2);
    check("a_en_span", a_last_en_cyc - a_start_cyc, 7);
    check("a_en_count", a_en_total - e0, 8);
    check("a_rx_count", a_rx - r0, 1);

    // A: a run of back-to-back words
    send_a(8'h00, dc);
    send_a(8'hFF, dc);
    for (int i = 0; i < 6; i++) send_a(8'($urandom), dc);
    for (n = 0; n < 3000 && (a_q.size() != 0 || a_busy); n++) @(negedge clk);
    check("a_drain_burst", a_q.size(), 0);

    // B: valid held high across two frames, 0x01 then 0xFF
    @(negedge clk);
    b_data  = 8'h01;
    b_valid = 1'b1;
    b_q.push_back({1'b0, 8'h01});
    @(negedge clk);
    b_data = 8'hFF;
    b_q.push_back({1'b0, 8'hFF});
    for (n = 0; n < 500 && !b_rdy; n++) @(negedge clk);
    check("b_ready_low_cycles", n, 12 * B_DIV + 1 + B_GAP);
    @(negedge clk);
    b_valid = 1'b0;
    for (n = 0; n < 3000 && (b_q.size() != 0 || b_busy); n++) @(negedge clk);
    check("b_drain_pair", b_q.size(), 0);
    check("b_interframe_gap", b_gap, B_GAP + 2 + B_DIV);

    // B: random words with one single-bit error injected in flight
    nerr0 = b_nerr;
    r0    = b_rx;
    for (int i = 0; i < 256; i++) send_b(8'($urandom), i == 77);
    for (n = 0; n < 3000 && (b_q.size() != 0 || b_busy); n++) @(negedge clk);
    check("b_drain_random", b_q.size(), 0);
    check("b_rx_random", b_rx - r0, 256);
    check("b_num_errors", b_nerr - nerr0, 1);

    // A: reset during bit 3 of 0x96, then 0x5A
    send_a(8'h96, dc);
    a_q.delete();
    for (n = 0; n < 100 && a_cnt != 3; n++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("a_async_reset", {a_rdy, a_ser, a_en, a_start, a_busy}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("a_ready_after_midreset", a_rdy, 1);
    r0 = a_rx;
    send_a(8'h5A, dc);
    for (n = 0; n < 3000 && (a_q.size() != 0 || a_busy); n++) @(negedge clk);
    check("a_drain_after_reset", a_q.size(), 0);
    check("a_rx_after_reset", a_rx - r0, 1);

    // idle with valid low
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("a_idle", {a_rdy, a_ser, a_en, a_start}, 4'b1000);
      check("b_idle", {b_rdy, b_ser, b_en, b_start}, 4'b1000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
